// File: rtl/present_pkg.sv
// Shared definitions for the iterative PRESENT-style encipher: S-box, bit permutation
// index helper and the controller state encoding.
package present_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fsm_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

    // Destination of source bit i under the pLayer; the top bit is a fixed point.
    function automatic int unsigned player_idx(input int unsigned i, input int unsigned block_w);
        if (i == block_w - 1) begin
            return i;
        end
        return (i * block_w / 4) % (block_w - 1);
    endfunction

endpackage

// File: rtl/present_round.sv
// One combinational cipher round: key mix, nibble-wise S-box layer, then bit permutation.
module present_round
    import present_pkg::*;
#(
    parameter int unsigned BLOCK_W = 16
) (
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] rkey,
    output logic [BLOCK_W-1:0] next_state
);

    logic [BLOCK_W-1:0] mixed;
    logic [BLOCK_W-1:0] subst;

    assign mixed = state ^ rkey;

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sbox
        assign subst[4*n +: 4] = sbox4(mixed[4*n +: 4]);
    end

    // Constant destination per bit, so the permutation is pure wiring.
    for (genvar i = 0; i < BLOCK_W; i++) begin : g_perm
        localparam int unsigned Dst = player_idx(i, BLOCK_W);
        assign next_state[Dst] = subst[i];
    end

endmodule

// File: rtl/present_iter_encipher.sv
// Iterative PRESENT-style encipher: one round per clock through a shared datapath, key
// schedule computed alongside, final whitening XOR, valid/ready on both sides.
module present_iter_encipher
    import present_pkg::*;
#(
    parameter int unsigned BLOCK_W    = 16,
    parameter int unsigned KEY_W      = 32,
    parameter int unsigned NUM_ROUNDS = 7,
    parameter int unsigned ROT        = 19,
    parameter int unsigned RC_LSB     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] ptext,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ctext,
    output logic               busy
);

    localparam int unsigned RC_W = $clog2(NUM_ROUNDS + 1);

    if (BLOCK_W % 4 != 0 || BLOCK_W < 8 || KEY_W < BLOCK_W || NUM_ROUNDS < 1 ||
        ROT == 0 || ROT >= KEY_W || RC_LSB + RC_W > KEY_W - 4) begin : g_param_check
        $error("present_iter_encipher: illegal parameter combination");
    end

    fsm_e               fsm_q, fsm_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RC_W-1:0]    rnd_q, rnd_d;
    logic [BLOCK_W-1:0] ctext_q, ctext_d;

    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic [KEY_W-1:0]   key_rot;
    logic [KEY_W-1:0]   key_next;
    logic               last_round;
    logic               accept;

    assign round_key = key_q[KEY_W-1 -: BLOCK_W];

    present_round #(
        .BLOCK_W(BLOCK_W)
    ) u_round (
        .state     (state_q),
        .rkey      (round_key),
        .next_state(round_out)
    );

    // Round-key update; the S-box nibble and the counter field never overlap.
    always_comb begin
        key_rot  = (key_q << ROT) | (key_q >> (KEY_W - ROT));
        key_next = key_rot;
        key_next[KEY_W-1 -: 4]   = sbox4(key_rot[KEY_W-1 -: 4]);
        key_next[RC_LSB +: RC_W] = key_rot[RC_LSB +: RC_W] ^ rnd_q;
    end

    assign last_round = (rnd_q == RC_W'(NUM_ROUNDS));

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready  = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q == StRun);
    assign ctext     = ctext_q;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        ctext_d = ctext_q;

        unique case (fsm_q)
            StIdle: begin
                if (accept) begin
                    state_d = ptext;
                    key_d   = key;
                    rnd_d   = RC_W'(1);
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = round_out;
                key_d   = key_next;
                if (last_round) begin
                    ctext_d = round_out ^ key_next[KEY_W-1 -: BLOCK_W];
                    fsm_d   = StDone;
                end else begin
                    rnd_d = rnd_q + RC_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = ptext;
                        key_d   = key;
                        rnd_d   = RC_W'(1);
                        fsm_d   = StRun;
                    end else begin
                        fsm_d = StIdle;
                    end
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            ctext_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            ctext_q <= ctext_d;
        end
    end

endmodule

// File: doc/present_iter_encipher.md
Name: present_iter_encipher

Overview:
Iterative, parametrised PRESENT-style block encipher with an on-the-fly key schedule.
- Each accepted block runs one round per clock through a single shared round datapath.
- A final whitening XOR follows the last round.
- Valid/ready handshakes on both sides, so it can sit between a plaintext source and a ciphertext sink in the crypto datapath.
- Supersedes the fixed 16-bit unrolled encipher; block width, key width and round count are generic.

Parameters:
- BLOCK_W, 16: block width in bits; multiple of 4, ≥8.
- KEY_W, 32: key register width; ≥ BLOCK_W.
- NUM_ROUNDS, 7: number of rounds, ≥1.
- ROT, 19: key-register left-rotate amount per round, 0 < ROT < KEY_W.
- RC_LSB, 8: LSB position where the round counter is XORed into the key register.
- Derived, not overridable: RC_W = $clog2(NUM_ROUNDS+1). Constraint: RC_LSB+RC_W ≤ KEY_W-4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ptext/key valid.
- in_ready  out  1  block accepted when in_valid & in_ready.
- ptext  in  BLOCK_W  plaintext.
- key  in  KEY_W  cipher key; sampled only at acceptance.
- out_valid  out  1  ctext valid.
- out_ready  in  1  sink accepts when out_valid & out_ready.
- ctext  out  BLOCK_W  ciphertext.
- busy  out  1  high while in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE. Registers: state (BLOCK_W), key_reg (KEY_W), rnd (RC_W), ctext_r.
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - FSM → IDLE; state, key_reg, rnd and ctext cleared to 0.
  - out_valid=0, busy=0. In-flight block is discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- in_ready = (IDLE) | (DONE & out_ready). Combinational from out_ready, with no path from in_valid.
- Acceptance: state ← ptext, key_reg ← key, rnd ← 1, FSM → RUN.
- RUN, one round per cycle, with round key K = key_reg[KEY_W-1 -: BLOCK_W]:
  - Round function: state ← P(S(state ^ K)).
  - S: 4-bit PRESENT S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} on every nibble.
  - P: bit i → bit (i*BLOCK_W/4) mod (BLOCK_W-1) for i < BLOCK_W-1; bit BLOCK_W-1 stays in place.
  - Key update, same edge:
    - rotate key_reg left by ROT;
    - top nibble ← S(top nibble);
    - bits [RC_LSB +: RC_W] ^= rnd.
  - rnd increments.
- Last round (rnd == NUM_ROUNDS):
  - ctext_r ← next_state ^ next_key[KEY_W-1 -: BLOCK_W], where next_state and next_key are the values computed in that cycle.
  - FSM → DONE.
- Latency: out_valid rises exactly NUM_ROUNDS cycles after the acceptance edge.
- in_valid is ignored in RUN (in_ready=0). ptext/key changes during RUN have no effect.
- DONE: out_valid=1 and ctext stable until out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & in_valid → accept the new block in the same cycle, go to RUN. This gives back-to-back throughput of one block per NUM_ROUNDS+1 cycles.
- ctext holds its last value in IDLE/RUN; it is only meaningful when out_valid=1.
- All arithmetic is bitwise. rnd never wraps because RC_W covers NUM_ROUNDS.

Decomposition:
- Package present_pkg: SBOX constant array, sbox4 function, player_idx function (parametrised by BLOCK_W), FSM state enum.
- Sub-module present_round (combinational, parameter BLOCK_W): inputs state and round key, output P(S(state^K)).
- Key schedule and FSM stay in the top module.

Test Plan:
1. NUM_ROUNDS=1, BLOCK_W=16, KEY_W=32, ROT=19, RC_LSB=8; ptext=0x0000, key=0x0000_0000 → out_valid 1 cycle after accept, ctext=0x3F00.
2. Defaults, 200 random ptext/key pairs with out_ready=1 → ctext matches the bench golden model; out_valid exactly 7 cycles after each acceptance.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and ctext stable, in_ready=0, no new acceptance; then out_ready=1 → one transfer, then IDLE.
4. Back-to-back: in_valid held high with out_ready=1 → a new block is accepted in the same cycle each result is taken; steady-state period 8 cycles at defaults; results in order.
5. Reset mid-RUN (rst at round 3) → next cycle IDLE, out_valid=0, busy=0, in_ready=1; the following block's result is correct and unaffected.
6. Change ptext/key and pulse in_valid during RUN → no acceptance, and the result equals that of the originally accepted inputs.
